// File: rtl/app_instr_tx.sv
// Transmit buffer for softMC application instructions: classifies host words,
// tags END_ISEQ entries, and releases a sequence once it is complete or the buffer fills.
module app_instr_tx #(
  parameter int         DEPTH          = 16,
  parameter int         AW             = $clog2(DEPTH),
  parameter logic [3:0] END_ISEQ       = 4'b0100,
  parameter int         CAS_OFFSET     = 28,
  parameter int         WE_OFFSET      = 27,
  parameter int         LONG_WR_OFFSET = 26,
  parameter int         BURST_OFFSET   = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [31:0]   host_data,
  output logic          app_en,
  input  logic          app_ack,
  output logic [31:0]   app_instr,
  output logic          iseq_sent,
  output logic [AW:0]   level
);

  typedef enum logic {W_INSTR, W_DATA} wstate_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic [AW:0]   pend_ends_reg, pend_ends_next;
  wstate_t       wstate_reg;
  logic [3:0]    wr_cnt_reg;
  logic          iseq_sent_reg;

  logic        full, empty, push, pop, is_long_wr, push_end, head_end;
  logic [32:0] head;

  assign full       = (level_reg == FULL_LEVEL);
  assign empty      = (level_reg == '0);
  assign host_ready = ~full & ~rst;
  // Release depends only on registered state, never on app_ack.
  assign app_en     = ~empty & ((pend_ends_reg != '0) | full);
  assign push       = host_valid & host_ready;
  assign pop        = app_en & app_ack;

  assign head       = mem[rd_ptr_reg];
  assign app_instr  = head[31:0];
  assign head_end   = head[32];
  assign iseq_sent  = iseq_sent_reg;
  assign level      = level_reg;

  assign is_long_wr = host_data[31] & ~host_data[CAS_OFFSET] & ~host_data[WE_OFFSET]
                    & host_data[LONG_WR_OFFSET] & host_data[BURST_OFFSET];
  // Payload words are never tagged, even if they look like END_ISEQ.
  assign push_end   = (wstate_reg == W_INSTR) & ~is_long_wr & (host_data[31:28] == END_ISEQ);

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    pend_ends_next = pend_ends_reg;
    if ((push & push_end) && !(pop & head_end))
      pend_ends_next = pend_ends_reg + 1'b1;
    else if (!(push & push_end) && (pop & head_end))
      pend_ends_next = pend_ends_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {push_end, host_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      pend_ends_reg <= '0;
      wstate_reg    <= W_INSTR;
      wr_cnt_reg    <= '0;
      iseq_sent_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg     <= level_next;
      pend_ends_reg <= pend_ends_next;
      iseq_sent_reg <= pop & head_end;
      if (push) begin
        case (wstate_reg)
          W_INSTR: begin
            if (is_long_wr) begin
              wstate_reg <= W_DATA;
              wr_cnt_reg <= 4'd15;
            end
          end
          W_DATA: begin
            if (wr_cnt_reg == 4'd0) wstate_reg <= W_INSTR;
            else                    wr_cnt_reg <= wr_cnt_reg - 1'b1;
          end
          default: wstate_reg <= W_INSTR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_app_instr_tx.sv
// Randomized bench for app_instr_tx against a queue-based model of the buffer,
// the long-write payload rule and the release condition.
module tb_app_instr_tx;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [3:0] END_ISEQ = 4'b0100;
  localparam int CAS_OFFSET = 28, WE_OFFSET = 27, LONG_WR_OFFSET = 26, BURST_OFFSET = 25;

  logic clk = 0, rst = 1, host_valid = 0, app_ack = 0;
  logic host_ready, app_en, iseq_sent;
  logic [31:0] host_data = '0, app_instr;
  logic [AW:0] level;

  app_instr_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .app_en(app_en), .app_ack(app_ack),
    .app_instr(app_instr), .iseq_sent(iseq_sent), .level(level)
  );

  always #5 clk = ~clk;

  // Model: queue of {is_end, word}; rem = payload words still owed to a long write.
  logic [32:0] q[$];
  int rem = 0;
  bit exp_sent = 0;
  int total = 0, bad = 0, cyc = 0;

  function automatic bit exp_en();
    int e = 0;
    foreach (q[i]) if (q[i][32]) e++;
    return (q.size() != 0) && (e != 0 || q.size() == DEPTH);
  endfunction

  function automatic bit exp_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic [31:0] exp_head();
    return (q.size() != 0) ? q[0][31:0] : 32'h0;
  endfunction

  function automatic logic [31:0] plain_word();
    logic [31:0] w = $urandom;
    if (w[31:28] == END_ISEQ) w[28] = ~w[28];
    if (w[31]) w[WE_OFFSET] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] end_word();
    logic [31:0] w = $urandom;
    w[31:28] = END_ISEQ;
    return w;
  endfunction

  function automatic logic [31:0] lw_word();
    logic [31:0] w = $urandom;
    w[31] = 1'b1; w[CAS_OFFSET] = 1'b0; w[WE_OFFSET] = 1'b0;
    w[LONG_WR_OFFSET] = 1'b1; w[BURST_OFFSET] = 1'b1;
    return w;
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input bit a);
    host_valid = v; host_data = d; app_ack = a;
    @(negedge clk);
  endtask

  // Apply this cycle's handshakes to the model, then move past the next edge.
  task automatic advance(output bit pushed);
    bit push, pop, pend;
    logic [31:0] w;
    push = host_valid && exp_ready();
    pop  = exp_en() && app_ack;
    pend = 0;
    if (pop) begin
      pend = q[0][32];
      $display("cyc %0d pop instr=%h end=%0d", cyc, q[0][31:0], q[0][32]);
      void'(q.pop_front());
    end
    if (push) begin
      w = host_data;
      if (rem > 0) begin
        rem--;
        q.push_back({1'b0, w});
      end else if (w[31] && !w[CAS_OFFSET] && !w[WE_OFFSET] && w[LONG_WR_OFFSET] && w[BURST_OFFSET]) begin
        rem = 16;
        q.push_back({1'b0, w});
      end else begin
        q.push_back({(w[31:28] == END_ISEQ), w});
      end
    end
    exp_sent = pend;
    pushed = push;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1; host_valid = 0; app_ack = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); rem = 0; exp_sent = 0;
  endtask

  task automatic test_reset();
    rst = 1; host_valid = 1; app_ack = 0;
    @(negedge clk);
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", host_ready); end
    @(posedge clk); #1;
    rst = 0; host_valid = 0;
    q.delete(); rem = 0; exp_sent = 0;
    @(negedge clk);
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", app_en); end
    total++; if (iseq_sent !== 1'b0) begin bad++; $display("FAIL reset_sent got=%b exp=0", iseq_sent); end
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", host_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] w[4];
    int pops = 0, sents = 0;
    bit p;
    for (int i = 0; i < 3; i++) w[i] = plain_word();
    w[3] = end_word();
    for (int c = 0; c < 12; c++) begin
      drive(c < 4, (c < 4) ? w[c] : 32'h0, 1'b1);
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL basic_en c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      if (exp_en()) begin
        total++; if (app_instr !== exp_head()) begin bad++; $display("FAIL basic_instr c=%0d got=%h exp=%h", c, app_instr, exp_head()); end
      end
      total++; if (iseq_sent !== exp_sent) begin bad++; $display("FAIL basic_sent c=%0d got=%b exp=%b", c, iseq_sent, exp_sent); end
      total++; if (level !== (AW+1)'(q.size())) begin bad++; $display("FAIL basic_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
      if (app_en && app_ack) pops++;
      if (iseq_sent) sents++;
      advance(p);
    end
    total++; if (pops !== 4) begin bad++; $display("FAIL basic_pops got=%0d exp=4", pops); end
    total++; if (sents !== 1) begin bad++; $display("FAIL basic_sent_count got=%0d exp=1", sents); end
  endtask

  task automatic test_long_write();
    logic [31:0] w[18];
    int idx = 0, pops = 0, sents = 0;
    bit p;
    w[0] = lw_word();
    for (int i = 1; i <= 16; i++) w[i] = $urandom;
    w[5][31:28] = END_ISEQ;
    w[17] = end_word();
    for (int c = 0; c < 45; c++) begin
      drive(idx < 18, (idx < 18) ? w[idx] : 32'h0, 1'b1);
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL lw_en c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      total++; if (host_ready !== exp_ready()) begin bad++; $display("FAIL lw_ready c=%0d got=%b exp=%b", c, host_ready, exp_ready()); end
      if (exp_en()) begin
        total++; if (app_instr !== exp_head()) begin bad++; $display("FAIL lw_instr c=%0d got=%h exp=%h", c, app_instr, exp_head()); end
      end
      total++; if (iseq_sent !== exp_sent) begin bad++; $display("FAIL lw_sent c=%0d got=%b exp=%b", c, iseq_sent, exp_sent); end
      if (app_en && app_ack) pops++;
      if (iseq_sent) sents++;
      advance(p);
      if (p) idx++;
    end
    total++; if (pops !== 18) begin bad++; $display("FAIL lw_pops got=%0d exp=18", pops); end
    total++; if (sents !== 1) begin bad++; $display("FAIL lw_sent_count got=%0d exp=1", sents); end
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    bit p;
    first = plain_word();
    drive(1, first, 0); advance(p);
    for (int i = 0; i < 2; i++) begin drive(1, plain_word(), 0); advance(p); end
    drive(1, end_word(), 0); advance(p);
    for (int c = 0; c < 10; c++) begin
      drive(0, 32'h0, 0);
      total++; if (app_en !== 1'b1) begin bad++; $display("FAIL bp_en_hold c=%0d got=%b exp=1", c, app_en); end
      total++; if (app_instr !== first) begin bad++; $display("FAIL bp_instr_hold c=%0d got=%h exp=%h", c, app_instr, first); end
      advance(p);
    end
    for (int c = 0; c < 7; c++) begin
      drive(0, 32'h0, 1);
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL bp_en c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      if (exp_en()) begin
        total++; if (app_instr !== exp_head()) begin bad++; $display("FAIL bp_instr c=%0d got=%h exp=%h", c, app_instr, exp_head()); end
      end
      total++; if (iseq_sent !== exp_sent) begin bad++; $display("FAIL bp_sent c=%0d got=%b exp=%b", c, iseq_sent, exp_sent); end
      advance(p);
    end
  endtask

  task automatic test_full();
    bit p;
    for (int i = 0; i < DEPTH; i++) begin drive(1, plain_word(), 0); advance(p); end
    drive(1, plain_word(), 0);
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", host_ready); end
    total++; if (app_en !== 1'b1) begin bad++; $display("FAIL full_en got=%b exp=1", app_en); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
    advance(p);
    for (int c = 0; c < 6; c++) begin
      drive(1, plain_word(), 1);
      total++; if (host_ready !== exp_ready()) begin bad++; $display("FAIL full_ready_rec c=%0d got=%b exp=%b", c, host_ready, exp_ready()); end
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL full_en_hs c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      total++; if (level !== (AW+1)'(q.size())) begin bad++; $display("FAIL full_level_hs c=%0d got=%0d exp=%0d", c, level, q.size()); end
      advance(p);
    end
    apply_reset();
  endtask

  task automatic test_two_sequences();
    logic [31:0] w[6];
    int sents = 0;
    bit p;
    w[0] = plain_word(); w[1] = plain_word(); w[2] = end_word();
    w[3] = plain_word(); w[4] = plain_word(); w[5] = end_word();
    for (int i = 0; i < 3; i++) begin drive(1, w[i], 0); advance(p); end
    for (int c = 0; c < 10; c++) begin
      drive(c < 3, (c < 3) ? w[c+3] : 32'h0, 1);
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL two_en c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      if (exp_en()) begin
        total++; if (app_instr !== exp_head()) begin bad++; $display("FAIL two_instr c=%0d got=%h exp=%h", c, app_instr, exp_head()); end
      end
      total++; if (iseq_sent !== exp_sent) begin bad++; $display("FAIL two_sent c=%0d got=%b exp=%b", c, iseq_sent, exp_sent); end
      if (iseq_sent) sents++;
      advance(p);
    end
    total++; if (sents !== 2) begin bad++; $display("FAIL two_sent_count got=%0d exp=2", sents); end
    total++; if (level !== '0) begin bad++; $display("FAIL two_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    bit p;
    drive(1, lw_word(), 0); advance(p);
    for (int i = 0; i < 8; i++) begin drive(1, $urandom, 0); advance(p); end
    drive(0, 32'h0, 0);
    total++; if (level !== 5'd9) begin bad++; $display("FAIL mid_level_pre got=%0d exp=9", level); end
    apply_reset();
    drive(0, 32'h0, 0);
    total++; if (level !== '0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level); end
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL mid_en got=%b exp=0", app_en); end
    advance(p);
    drive(1, end_word(), 0); advance(p);
    drive(0, 32'h0, 1);
    total++; if (app_en !== 1'b1) begin bad++; $display("FAIL mid_end_release got=%b exp=1", app_en); end
    advance(p);
    drive(0, 32'h0, 1);
    total++; if (iseq_sent !== 1'b1) begin bad++; $display("FAIL mid_end_sent got=%b exp=1", iseq_sent); end
    advance(p);
  endtask

  task automatic test_random();
    bit p, v, a;
    int r;
    logic [31:0] w;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 99);
      w = (r < 12) ? end_word() : (r < 16) ? lw_word() : plain_word();
      drive(v, w, a);
      total++; if (host_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, host_ready, exp_ready()); end
      total++; if (app_en !== exp_en()) begin bad++; $display("FAIL rnd_en c=%0d got=%b exp=%b", c, app_en, exp_en()); end
      if (q.size() != 0) begin
        total++; if (app_instr !== exp_head()) begin bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, app_instr, exp_head()); end
      end
      total++; if (iseq_sent !== exp_sent) begin bad++; $display("FAIL rnd_sent c=%0d got=%b exp=%b", c, iseq_sent, exp_sent); end
      total++; if (level !== (AW+1)'(q.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
      advance(p);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_long_write();
    test_backpressure();
    test_full();
    test_two_sequences();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
